// File: rtl/transpose_tile_pingpong.sv
// transpose_tile_pingpong: LANES x LANES tile transposer with two ping-pong banks.
// Rows stream into the write bank while the other bank drains one column per beat.
// Optional macro TRANS_ZERO_PAD_EN: honour cfg_rows and zero column elements beyond
// the valid rows. Without it every tile is LANES rows and no masking is built.
//
// Handshake: a beat moves at a rising edge where vld and rdy are both high; a
// producer that raised vld keeps it high with pd unchanged until rdy is seen.
module transpose_tile_pingpong #(
    parameter int DW         = 16,
    parameter int LANES      = 8,
    parameter int LOG2_LANES = 3,
    parameter int TILE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] cfg_tile_num,
    input  logic [LOG2_LANES:0]   cfg_rows,
    input  logic [LOG2_LANES:0]   cfg_cols,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DW*LANES-1:0]   in_pd,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DW*LANES-1:0]   out_pd,
    output logic                  busy,
    output logic                  done
);
    localparam int W = DW * LANES;
    localparam logic [LOG2_LANES-1:0] LAST_IDX = LOG2_LANES'(LANES - 1);
    localparam logic [LOG2_LANES-1:0] IDX_ONE  = LOG2_LANES'(1);
    localparam logic [LOG2_LANES:0]   CFG_ONE  = (LOG2_LANES + 1)'(1);
    localparam logic [TILE_CNT_W-1:0] TILE_ONE = TILE_CNT_W'(1);

    typedef enum logic {RD_IDLE, RD_EMIT} rd_state_e;

    rd_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [TILE_CNT_W-1:0] tile_num_q, tile_num_d;
    logic [LOG2_LANES-1:0] last_row_q, last_row_d;
    logic [LOG2_LANES-1:0] last_col_q, last_col_d;
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [LOG2_LANES-1:0] wr_row_q, wr_row_d;
    logic [LOG2_LANES-1:0] rd_col_q, rd_col_d;
    logic [TILE_CNT_W-1:0] tiles_wr_q, tiles_wr_d;
    logic [TILE_CNT_W-1:0] tiles_rd_q, tiles_rd_d;
    logic                  out_vld_q, out_vld_d;
    logic [W-1:0]          out_pd_q, out_pd_d;

    logic [W-1:0]          mem_q [2][LANES];

    logic                  job_start;
    logic                  job_end;
    logic                  wr_fire;
    logic                  out_fire;
    logic                  rd_release;
    logic                  load;
    logic                  load_bank;
    logic [LOG2_LANES-1:0] load_col;
    logic [W-1:0]          col_data;
    logic [LOG2_LANES-1:0] start_last_row;
    logic [LOG2_LANES-1:0] start_last_col;

    assign in_rdy    = busy_q & ~full_q[wr_bank_q] & (tiles_wr_q < tile_num_q);
    assign wr_fire   = in_vld & in_rdy;
    assign out_fire  = out_vld_q & out_rdy;
    assign job_start = start & ~busy_q & (cfg_tile_num != '0);
    assign job_end   = rd_release & (tiles_rd_q == tile_num_q - TILE_ONE);

    assign out_vld = out_vld_q;
    assign out_pd  = out_pd_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifndef TRANS_ZERO_PAD_EN
    logic unused_cfg_rows;
    assign unused_cfg_rows = ^cfg_rows;
`endif

    // Decode the tile shape offered with start; a zero field means a full LANES edge
    always_comb begin
        start_last_col = (cfg_cols == '0) ? LAST_IDX : LOG2_LANES'(cfg_cols - CFG_ONE);
`ifdef TRANS_ZERO_PAD_EN
        start_last_row = (cfg_rows == '0) ? LAST_IDX : LOG2_LANES'(cfg_rows - CFG_ONE);
`else
        start_last_row = LAST_IDX;
`endif
    end

    // Read FSM: pick which column (if any) is loaded into the output register
    always_comb begin
        state_d    = state_q;
        out_vld_d  = out_vld_q;
        rd_col_d   = rd_col_q;
        rd_bank_d  = rd_bank_q;
        tiles_rd_d = tiles_rd_q;
        rd_release = 1'b0;
        load       = 1'b0;
        load_bank  = rd_bank_q;
        load_col   = '0;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load    = 1'b1;
                    state_d = RD_EMIT;
                end
            end
            RD_EMIT: begin
                if (out_fire) begin
                    if (rd_col_q == last_col_q) begin
                        // Tile drained: hand the bank back to the write side
                        rd_release = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        rd_col_d   = '0;
                        tiles_rd_d = tiles_rd_q + TILE_ONE;
                        if (full_q[~rd_bank_q]) begin
                            load      = 1'b1;
                            load_bank = ~rd_bank_q;
                        end else begin
                            out_vld_d = 1'b0;
                            state_d   = RD_IDLE;
                        end
                    end else begin
                        rd_col_d = rd_col_q + IDX_ONE;
                        load     = 1'b1;
                        load_col = rd_col_q + IDX_ONE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (load) begin
            out_vld_d = 1'b1;
        end
        if (job_start) begin
            rd_bank_d  = 1'b0;
            rd_col_d   = '0;
            tiles_rd_d = '0;
        end
    end

    // Gather one column of the selected bank; rows past the tile edge read as zero when padding
    always_comb begin
        col_data = '0;
        for (int r = 0; r < LANES; r++) begin
            col_data[r*DW +: DW] = mem_q[load_bank][r][int'(load_col)*DW +: DW];
`ifdef TRANS_ZERO_PAD_EN
            if (LOG2_LANES'(r) > last_row_q) begin
                col_data[r*DW +: DW] = '0;
            end
`endif
        end
        out_pd_d = load ? col_data : out_pd_q;
    end

    // Job control and write side: row pointer, bank flip, full flags, busy/done
    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        tile_num_d = tile_num_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        wr_row_d   = wr_row_q;
        wr_bank_d  = wr_bank_q;
        tiles_wr_d = tiles_wr_q;
        full_d     = full_q;
        if (wr_fire) begin
            if (wr_row_q == last_row_q) begin
                full_d[wr_bank_q] = 1'b1;
                wr_row_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                tiles_wr_d        = tiles_wr_q + TILE_ONE;
            end else begin
                wr_row_d = wr_row_q + IDX_ONE;
            end
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (job_end) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (start && !busy_q && (cfg_tile_num == '0)) begin
            done_d = 1'b1;
        end
        if (job_start) begin
            busy_d     = 1'b1;
            tile_num_d = cfg_tile_num;
            last_row_d = start_last_row;
            last_col_d = start_last_col;
            wr_row_d   = '0;
            wr_bank_d  = 1'b0;
            tiles_wr_d = '0;
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tile_num_q <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_col_q   <= '0;
            tiles_wr_q <= '0;
            tiles_rd_q <= '0;
            out_vld_q  <= 1'b0;
            out_pd_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tile_num_q <= tile_num_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_col_q   <= rd_col_d;
            tiles_wr_q <= tiles_wr_d;
            tiles_rd_q <= tiles_rd_d;
            out_vld_q  <= out_vld_d;
            out_pd_q   <= out_pd_d;
        end
    end

    // Bank storage; contents need no reset because full flags guard every read
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_row_q] <= in_pd;
        end
    end

endmodule

// File: tb/tb_transpose_tile_pingpong.sv
// Bench for transpose_tile_pingpong (DW=8, LANES=4). Expected columns come from a
// plain-array transpose of the rows the bench generates.
`timescale 1ns/1ps
module tb_transpose_tile_pingpong;
    localparam int DW         = 8;
    localparam int LANES      = 4;
    localparam int LOG2_LANES = 2;
    localparam int TILE_CNT_W = 16;
    localparam int W          = DW * LANES;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [TILE_CNT_W-1:0] cfg_tile_num = '0;
    logic [LOG2_LANES:0]   cfg_rows = '0;
    logic [LOG2_LANES:0]   cfg_cols = '0;
    logic                  in_vld = 1'b0;
    logic                  in_rdy;
    logic [W-1:0]          in_pd = '0;
    logic                  out_vld;
    logic                  out_rdy = 1'b0;
    logic [W-1:0]          out_pd;
    logic                  busy;
    logic                  done;

    always #5 clk = ~clk;

    transpose_tile_pingpong #(
        .DW(DW), .LANES(LANES), .LOG2_LANES(LOG2_LANES), .TILE_CNT_W(TILE_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_tile_num(cfg_tile_num),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_pd(in_pd), .out_vld(out_vld), .out_rdy(out_rdy), .out_pd(out_pd),
        .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] in_rows_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    int   done_cnt, done_cyc, last_out_cyc, hold_err, in_stall_cnt, in_stall_early;
    bit   timeout_flag;
    logic busy_after_start, busy_at_done;

    // Reference model: generate rows for tn tiles and the transposed columns expected
    task automatic build_job(input int tn, input int rows, input int cols, input bit fixed_first);
        int           rows_eff, cols_eff;
        logic [W-1:0] tile [LANES];
        logic [W-1:0] rw, word;
        cols_eff = (cols == 0) ? LANES : cols;
`ifdef TRANS_ZERO_PAD_EN
        rows_eff = (rows == 0) ? LANES : rows;
`else
        rows_eff = LANES;
`endif
        in_rows_q.delete();
        exp_q.delete();
        for (int t = 0; t < tn; t++) begin
            for (int r = 0; r < rows_eff; r++) begin
                for (int e = 0; e < LANES; e++) begin
                    if (fixed_first && t == 0) rw[e*DW +: DW] = DW'(r * 16 + e);
                    else                       rw[e*DW +: DW] = DW'($urandom);
                end
                tile[r] = rw;
                in_rows_q.push_back(rw);
            end
            for (int c = 0; c < cols_eff; c++) begin
                word = '0;
                for (int r = 0; r < rows_eff; r++) begin
                    rw = tile[r];
                    word[r*DW +: DW] = rw[c*DW +: DW];
                end
                exp_q.push_back(word);
            end
        end
    endtask

    // Driver/monitor: start a job, feed in_rows_q, collect output beats into got_q
    task automatic drive_job(input int tn, input int rows, input int cols,
                             input int vld_pct, input int rdy_pct,
                             input int stall_from, input int stall_len,
                             input int restart_at, input int abort_at, input int max_cyc);
        int           cyc, rows_sent;
        bit           have_cur, prev_hold, stop;
        logic [W-1:0] cur, prev_pd;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; last_out_cyc = -1; hold_err = 0;
        in_stall_cnt = 0; in_stall_early = 0; timeout_flag = 0;
        busy_after_start = 1'bx; busy_at_done = 1'bx;
        rows_sent = 0; have_cur = 0; prev_hold = 0; stop = 0; prev_pd = '0; cur = '0;
        @(negedge clk);
        cyc = 0;
        start = 1'b1;
        cfg_tile_num = TILE_CNT_W'(tn);
        cfg_rows = (LOG2_LANES + 1)'(rows);
        cfg_cols = (LOG2_LANES + 1)'(cols);
        in_vld = 1'b0;
        out_rdy = 1'b0;
        while (!stop) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy_after_start = busy;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
            if (prev_hold && (!out_vld || out_pd !== prev_pd)) hold_err++;
            start = (cyc == restart_at);
            if (start) begin
                cfg_tile_num = TILE_CNT_W'(tn + 3);
                cfg_rows = (LOG2_LANES + 1)'(1);
                cfg_cols = (LOG2_LANES + 1)'(1);
            end else begin
                cfg_tile_num = TILE_CNT_W'($urandom);
                cfg_rows = (LOG2_LANES + 1)'($urandom);
                cfg_cols = (LOG2_LANES + 1)'($urandom);
            end
            if (!have_cur && in_rows_q.size() > 0 && $urandom_range(1, 100) <= vld_pct) begin
                cur = in_rows_q.pop_front();
                have_cur = 1;
            end
            in_vld = have_cur;
            in_pd = have_cur ? cur : W'($urandom);
            out_rdy = ($urandom_range(1, 100) <= rdy_pct) &&
                      !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (in_vld && in_rdy) begin
                have_cur = 0;
                rows_sent++;
            end else if (in_vld) begin
                in_stall_cnt++;
                if (rows_sent < 8) in_stall_early++;
            end
            if (out_vld && out_rdy) begin
                got_q.push_back(out_pd);
                last_out_cyc = cyc;
            end
            prev_hold = out_vld && !out_rdy;
            prev_pd = out_pd;
            if (cyc == abort_at) stop = 1;
            else if (done_cnt > 0 && cyc >= done_cyc + 2) stop = 1;
            else if (cyc >= max_cyc) begin
                timeout_flag = 1;
                stop = 1;
            end
        end
        start = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_vec++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b, expected 0", done); end
        n_vec++; if (in_rdy !== 1'b0)  begin n_err++; $display("FAIL reset_in_rdy: got %b, expected 0", in_rdy); end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld: got %b, expected 0", out_vld); end
        n_vec++; if (out_pd !== '0)    begin n_err++; $display("FAIL reset_out_pd: got %h, expected 0", out_pd); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0 || in_rdy !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: busy=%b in_rdy=%b, expected 0/0", busy, in_rdy);
        end
    endtask

    task automatic test_full_tile();
        build_job(1, 0, 0, 1);
        drive_job(1, 0, 0, 100, 100, -1, 0, -1, -1, 300);
        n_vec++; if (timeout_flag) begin n_err++; $display("FAIL full_tile_timeout: got timeout, expected done"); end
        n_vec++; if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL full_tile_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL full_tile_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (busy_after_start !== 1'b1) begin n_err++; $display("FAIL full_tile_busy_rise: got %b, expected 1", busy_after_start); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL full_tile_done_count: got %0d, expected 1", done_cnt); end
        n_vec++; if (done_cyc != last_out_cyc + 1) begin
            n_err++; $display("FAIL full_tile_done_time: got cycle %0d, expected %0d", done_cyc, last_out_cyc + 1);
        end
        n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL full_tile_busy_fall: got %b, expected 0", busy_at_done); end
    endtask

    task automatic test_streaming();
        build_job(3, 0, 0, 0);
        drive_job(3, 0, 0, 100, 100, -1, 0, -1, -1, 400);
        n_vec++; if (timeout_flag) begin n_err++; $display("FAIL stream_timeout: got timeout, expected done"); end
        n_vec++; if (in_stall_early != 0) begin
            n_err++; $display("FAIL stream_in_rdy: got %0d stalls in first 8 rows, expected 0", in_stall_early);
        end
        n_vec++; if (got_q.size() != 12) begin n_err++; $display("FAIL stream_count: got %0d beats, expected 12", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL stream_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL stream_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        build_job(3, 0, 0, 0);
        drive_job(3, 0, 0, 100, 100, 7, 10, -1, -1, 400);
        n_vec++; if (timeout_flag) begin n_err++; $display("FAIL bp_timeout: got timeout, expected done"); end
        n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable stall cycles, expected 0", hold_err); end
        n_vec++; if (in_stall_cnt == 0) begin n_err++; $display("FAIL bp_in_rdy_drop: got 0 input stalls, expected some"); end
        n_vec++; if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL bp_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_partial();
        build_job(2, 2, 3, 1);
        drive_job(2, 2, 3, 70, 70, -1, 0, -1, -1, 400);
        n_vec++; if (timeout_flag) begin n_err++; $display("FAIL partial_timeout: got timeout, expected done"); end
        n_vec++; if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL partial_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL partial_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL partial_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_zero_and_restart();
        int done_seen;
        @(negedge clk);
        start = 1'b1;
        cfg_tile_num = '0;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b, expected 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b, expected 0", busy); end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL zero_quiet: got %0d active cycles, expected 0", done_seen); end
        build_job(1, 0, 0, 0);
        drive_job(1, 0, 0, 100, 100, -1, 0, 3, -1, 300);
        n_vec++; if (timeout_flag) begin n_err++; $display("FAIL restart_timeout: got timeout, expected done"); end
        n_vec++; if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL restart_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL restart_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL restart_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_job();
        build_job(2, 0, 0, 0);
        drive_job(2, 0, 0, 100, 100, -1, 0, -1, 8, 300);
        n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL midrst_active: got out_vld %b, expected 1", out_vld); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL midrst_out_vld: got %b, expected 0", out_vld); end
        n_vec++; if (in_rdy !== 1'b0)  begin n_err++; $display("FAIL midrst_in_rdy: got %b, expected 0", in_rdy); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        build_job(1, 0, 0, 0);
        drive_job(1, 0, 0, 100, 100, -1, 0, -1, -1, 300);
        n_vec++; if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL midrst_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL midrst_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL midrst_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_random();
        int tn, rows, cols;
        for (int j = 0; j < 5; j++) begin
            tn   = $urandom_range(1, 4);
            rows = $urandom_range(0, LANES);
            cols = $urandom_range(0, LANES);
            build_job(tn, rows, cols, 0);
            drive_job(tn, rows, cols, $urandom_range(30, 100), $urandom_range(30, 100), -1, 0, -1, -1, 1500);
            n_vec++; if (timeout_flag) begin n_err++; $display("FAIL random%0d_timeout: got timeout, expected done", j); end
            n_vec++; if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL random%0d_count: got %0d beats, expected %0d", j, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++; if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL random%0d_beat%0d: got %h, expected %h", j, i, got_q[i], exp_q[i]);
                end
            end
            n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL random%0d_hold: got %0d, expected 0", j, hold_err); end
            n_vec++; if (done_cnt != 1 || done_cyc != last_out_cyc + 1) begin
                n_err++; $display("FAIL random%0d_done: got count %0d at cycle %0d, expected 1 at %0d",
                                  j, done_cnt, done_cyc, last_out_cyc + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_streaming();
        test_backpressure();
        test_partial();
        test_zero_and_restart();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
